pattern_match_engine: RTL and testbench

PATTERN_MATCH_ENGINE -- requirements
Module: pattern_match_engine

---
 rtl/pattern_match_engine.sv | 171 +++++++++++++++++
 tb/tb_pattern_match_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_engine.sv
// -----------------------------------------------------------------------------
// pattern_match_engine
//
// Streaming pattern matcher. A programmable pattern of up to MAX_LEN symbols,
// each of which may be marked optional, is compared against an input symbol
// stream. All partial matches are tracked in parallel with a one-hot-per-slot
// active vector, so overlapping occurrences are all reported.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   cfg_we     in   write one pattern slot (also latches cfg_len, clears state)
//   cfg_idx    in   pattern slot index
//   cfg_sym    in   symbol for slot cfg_idx
//   cfg_opt    in   slot cfg_idx may be skipped
//   cfg_len    in   active pattern length (0 disables matching)
//   in_valid   in   in_sym is valid this cycle
//   in_sym     in   input symbol
//   match      out  one-cycle pulse, one cycle after the accepting symbol
//   match_cnt  out  saturating count of match pulses
//   busy       out  at least one partial match in progress
//
// Optional feature macro: PMATCH_CASE_FOLD_EN
//   When defined and DATA_W == 8, ASCII 'a'..'z' fold to 'A'..'Z' on both
//   the input symbol and the stored pattern before comparison. Otherwise the
//   comparison is exact and bitwise.
// -----------------------------------------------------------------------------
module pattern_match_engine #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
    input  logic [DATA_W-1:0]            cfg_sym,
    input  logic                         cfg_opt,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_sym,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         busy
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN+1);

    logic [DATA_W-1:0]  r_pat [MAX_LEN];
    logic [MAX_LEN-1:0] r_opt;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_act;
    logic               r_match;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_eq;
    logic [MAX_LEN-1:0] w_d;
    logic [MAX_LEN-1:0] w_lenMask;
    logic               w_hit;
    logic [MAX_LEN-1:0] w_actNext;
    logic               w_matchNext;

`ifdef PMATCH_CASE_FOLD_EN
    // Folding only makes sense for 8-bit ASCII symbols; other widths compare exactly.
    localparam bit FOLD_EN = (DATA_W == 8);

    function automatic logic [DATA_W-1:0] foldSym(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] f;
        f = s;
        if (FOLD_EN && (s >= DATA_W'(97)) && (s <= DATA_W'(122))) begin
            f = s - DATA_W'(32);
        end
        return f;
    endfunction
`else
    function automatic logic [DATA_W-1:0] foldSym(input logic [DATA_W-1:0] s);
        return s;
    endfunction
`endif

    // Per-slot symbol compare against the current input.
    always_comb begin
        w_eq = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_eq[i] = (foldSym(in_sym) == foldSym(r_pat[i]));
        end
    end

    // Advance the active vector. Slot 0 always restarts on a hit (its
    // optional bit is ignored so an empty prefix can never match). An
    // optional slot i inherits D[i-1] of the same symbol, which lets the
    // chain skip it without consuming input.
    always_comb begin
        w_d = '0;
        w_d[0] = w_eq[0];
        for (int i = 1; i < MAX_LEN; i++) begin
            w_d[i] = (r_act[i-1] & w_eq[i]) | (r_opt[i] & w_d[i-1]);
        end
    end

    // Slots at or beyond LEN are never active; the final slot LEN-1 produces
    // the match. A LEN of zero selects no slot, which disables matching.
    always_comb begin
        w_lenMask = '0;
        w_hit     = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_lenMask[i] = (i < int'(r_len));
            if (int'(r_len) == i + 1) begin
                w_hit = w_d[i];
            end
        end
    end

    // Configuration writes flush all partial matches and swallow any
    // concurrent input; idle input cycles leave the partial matches intact.
    always_comb begin
        w_actNext   = r_act;
        w_matchNext = 1'b0;
        if (cfg_we) begin
            w_actNext = '0;
        end else if (in_valid) begin
            w_actNext   = w_d & w_lenMask;
            w_matchNext = w_hit;
        end
    end

    // Pattern storage. Slot writes decode cfg_idx so an out-of-range index
    // touches nothing, while LEN is taken on every write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_pat[i] <= '0;
            end
            r_opt <= '0;
            r_len <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    r_pat[i] <= cfg_sym;
                    r_opt[i] <= cfg_opt;
                end
            end
            r_len <= cfg_len;
        end
    end

    // Match state: active vector, match pulse, busy flag and the saturating
    // counter, which steps together with the pulse it counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act   <= '0;
            r_match <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_act   <= w_actNext;
            r_match <= w_matchNext;
            r_busy  <= |w_actNext;
            if (w_matchNext && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pattern_match_engine.sv
// -----------------------------------------------------------------------------
// tb_pattern_match_engine
//
// Directed testbench for pattern_match_engine. Two instances share all
// inputs: u_dut with default parameters, u_dutSat with CNT_W=2 for the
// counter saturation scenario. Inputs change on the falling edge and
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_match_engine;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [7:0] cfg_sym;
    logic       cfg_opt;
    logic [3:0] cfg_len;
    logic       in_valid;
    logic [7:0] in_sym;

    logic        match;
    logic [15:0] match_cnt;
    logic        busy;
    logic        matchSat;
    logic [1:0]  matchCntSat;
    logic        busySat;

    int vecCount;
    int errCount;

    pattern_match_engine #(.DATA_W(8), .MAX_LEN(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
        .cfg_opt(cfg_opt), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_sym(in_sym),
        .match(match), .match_cnt(match_cnt), .busy(busy)
    );

    pattern_match_engine #(.DATA_W(8), .MAX_LEN(8), .CNT_W(2)) u_dutSat (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
        .cfg_opt(cfg_opt), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_sym(in_sym),
        .match(matchSat), .match_cnt(matchCntSat), .busy(busySat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-looking reset pulse that spans one full clock cycle.
    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b0;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Write every slot of a pattern; optMask bit i marks slot i optional.
    task automatic loadPattern(input string p, input logic [7:0] optMask, input int len);
        logic [7:0] ch;
        for (int i = 0; i < p.len(); i++) begin
            @(negedge clk);
            ch       = p[i];
            cfg_we   = 1'b1;
            cfg_idx  = 3'(i);
            cfg_sym  = ch;
            cfg_opt  = optMask[i];
            cfg_len  = 4'(len);
            in_valid = 1'b0;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Present one symbol and check the match pulse that follows it.
    task automatic sendSym(input logic [7:0] s, input logic expMatch, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_sym   = s;
        @(posedge clk);
        #1;
        vecCount++;
        if (match !== expMatch) begin
            errCount++;
            $display("[TB] FAIL %s sym=%c match got=%b exp=%b", tag, s, match, expMatch);
        end
    endtask

    // Present a string; expMask bit i is the expected match after character i.
    task automatic sendSeq(input string str, input logic [15:0] expMask, input string tag);
        logic [7:0] ch;
        for (int i = 0; i < str.len(); i++) begin
            ch = str[i];
            sendSym(ch, expMask[i], tag);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkCount(input logic [15:0] exp, input string tag);
        vecCount++;
        if (match_cnt !== exp) begin
            errCount++;
            $display("[TB] FAIL %s match_cnt got=%0d exp=%0d", tag, match_cnt, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        vecCount++;
        if ({match, match_cnt, busy} !== 18'd0) begin
            errCount++;
            $display("[TB] FAIL reset_main match=%b cnt=%0d busy=%b exp all 0", match, match_cnt, busy);
        end
        vecCount++;
        if ({matchSat, matchCntSat, busySat} !== 4'd0) begin
            errCount++;
            $display("[TB] FAIL reset_sat match=%b cnt=%0d busy=%b exp all 0", matchSat, matchCntSat, busySat);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_optional();
        resetDut();
        loadPattern("COLOUR", 8'b0001_0000, 6);
        sendSeq("COLORCOLOUR", 16'h0410, "optional_slot");
        idleCycle();
        checkCount(16'd2, "optional_count");
    endtask

    task automatic test_overlap();
        resetDut();
        loadPattern("ABA", 8'h00, 3);
        sendSeq("ABABA", 16'h0014, "overlap");
        idleCycle();
        checkCount(16'd2, "overlap_count");
    endtask

    task automatic test_gap();
        resetDut();
        loadPattern("CC", 8'h00, 2);
        sendSym("C", 1'b0, "gap_first");
        for (int g = 0; g < 3; g++) begin
            idleCycle();
            vecCount++;
            if (busy !== 1'b1 || match !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL gap_hold cycle=%0d busy=%b match=%b exp busy=1 match=0", g, busy, match);
            end
        end
        sendSym("C", 1'b1, "gap_second");
        idleCycle();
        checkCount(16'd1, "gap_count");
    endtask

    task automatic test_midstream_reset();
        resetDut();
        loadPattern("COLOR", 8'h00, 5);
        sendSeq("COL", 16'h0000, "midreset_prefix");
        vecCount++;
        if (busy !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL midreset_busy_before got=%b exp=1", busy);
        end
        #2;
        rst = 1'b0;
        #1;
        vecCount++;
        if (busy !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL midreset_async_clear busy got=%b exp=0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        sendSeq("OR", 16'h0000, "midreset_tail");
        idleCycle();
        checkCount(16'd0, "midreset_count");
    endtask

    task automatic test_saturate();
        logic [1:0] expCnt;
        resetDut();
        loadPattern("A", 8'h00, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sym   = "A";
            @(posedge clk);
            #1;
            expCnt = (k >= 3) ? 2'd3 : 2'(k);
            vecCount++;
            if (matchSat !== 1'b1 || matchCntSat !== expCnt) begin
                errCount++;
                $display("[TB] FAIL saturate k=%0d match=%b cnt=%0d exp match=1 cnt=%0d",
                         k, matchSat, matchCntSat, expCnt);
            end
        end
        idleCycle();
    endtask

    task automatic test_len_zero();
        resetDut();
        loadPattern("AB", 8'h00, 0);
        sendSeq("ABAB", 16'h0000, "len_zero");
        vecCount++;
        if (busy !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL len_zero_busy got=%b exp=0", busy);
        end
        idleCycle();
    endtask

    task automatic test_cfg_clear();
        resetDut();
        loadPattern("ABC", 8'h00, 3);
        sendSeq("AB", 16'h0000, "cfgclear_prefix");
        // Rewrite slot 2 while presenting the completing symbol; it must be dropped.
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = 3'd2;
        cfg_sym  = "C";
        cfg_opt  = 1'b0;
        cfg_len  = 4'd3;
        in_valid = 1'b1;
        in_sym   = "C";
        @(posedge clk);
        #1;
        vecCount++;
        if (busy !== 1'b0 || match !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL cfgclear_flush busy=%b match=%b exp 0 0", busy, match);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        sendSym("C", 1'b0, "cfgclear_after");
        sendSeq("ABC", 16'h0004, "cfgclear_rematch");
        idleCycle();
    endtask

    task automatic test_case_fold();
        logic [15:0] expMask;
`ifdef PMATCH_CASE_FOLD_EN
        expMask = 16'h0010;
`else
        expMask = 16'h0000;
`endif
        resetDut();
        loadPattern("COLOR", 8'h00, 5);
        sendSeq("color", expMask, "case_fold");
        sendSeq("COLOR", 16'h0010, "case_exact");
        idleCycle();
    endtask

    initial begin
        vecCount = 0;
        errCount = 0;
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_sym  = '0;
        cfg_opt  = 1'b0;
        cfg_len  = '0;
        in_valid = 1'b0;
        in_sym   = '0;

        test_reset();
        test_optional();
        test_overlap();
        test_gap();
        test_midstream_reset();
        test_saturate();
        test_len_zero();
        test_cfg_clear();
        test_case_fold();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
